// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI controller APB register block.
package spi_pkg;

    // Register byte offsets; PADDR[1:0] are ignored by the decoder.
    localparam logic [4:0] CTRL_OFS     = 5'h00;
    localparam logic [4:0] STATUS_OFS   = 5'h04;
    localparam logic [4:0] TXDATA_OFS   = 5'h08;
    localparam logic [4:0] RXDATA_OFS   = 5'h0C;
    localparam logic [4:0] IRQ_EN_OFS   = 5'h10;
    localparam logic [4:0] IRQ_STAT_OFS = 5'h14;
    localparam logic [4:0] DIV_OFS      = 5'h18;
    localparam logic [4:0] UNMAPPED_OFS = 5'h1C;

    // Interrupt source bit positions in IRQ_EN / IRQ_STAT.
    localparam int unsigned IRQ_TX_EMPTY = 0;
    localparam int unsigned IRQ_RX_AVAIL = 1;
    localparam int unsigned IRQ_RX_OVF   = 2;
    localparam int unsigned IRQ_W        = 3;

    // STATUS field positions.
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_COUNT = 4;
    localparam int unsigned ST_RX_COUNT = 8;
    localparam int unsigned ST_COUNT_W  = 3;

    // CTRL register layout; the last member is bit 0.
    typedef struct packed {
        logic cpha;
        logic cpol;
        logic spi_en;
    } ctrl_t;

endpackage

// File: rtl/spi_apb_regs_if.sv
// APB3 bus bundle between a bus master and the SPI register block.
interface spi_apb_regs_if;

    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR,
        output PWDATA,
        output PWRITE,
        output PSEL,
        output PENABLE,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
        input  PADDR,
        input  PWDATA,
        input  PWRITE,
        input  PSEL,
        input  PENABLE,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle, so the slot being read is reused.
module spi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads as zero when empty so downstream never sees stale data.
    assign rdata   = empty ? '0 : mem[rptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array; left unreset, contents are masked by the empty flag.
    always_ff @(posedge PCLK) begin
        if (PRESETN && do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/spi_apb_regs.sv
// APB register block for the SPI controller: control/divider registers,
// TX and RX frame FIFOs, sticky interrupt status and the engine frame port.
module spi_apb_regs
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    spi_apb_regs_if.slave     apb,
    output logic              IRQ,
    output logic              spi_en,
    output logic              cpol,
    output logic              cpha,
    output logic [7:0]        clk_div,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Register state.
    ctrl_t              ctrl_q;
    logic [7:0]         div_q;
    logic [IRQ_W-1:0]   irq_en_q;
    logic [IRQ_W-1:0]   irq_stat_q;
    logic [IRQ_W-1:0]   irq_stat_d;
    logic               irq_q;

    // Bus decode.
    logic [4:0]         reg_addr;
    logic               access;
    logic               err_raw;
    logic               slverr;
    logic               wr_ok;
    logic               rd_ok;
    logic [31:0]        rdata;
    logic [31:0]        status;

    // FIFO handshakes.
    logic               tx_push;
    logic               tx_pop;
    logic               tx_full;
    logic               tx_empty;
    logic [CW-1:0]      tx_count;
    logic               rx_push;
    logic               rx_pop;
    logic               rx_drop;
    logic               rx_full;
    logic               rx_empty;
    logic [CW-1:0]      rx_count;
    logic [DATA_W-1:0]  rx_head;
    logic               tx_empty_ev;
    logic [IRQ_W-1:0]   irq_set;
    logic [IRQ_W-1:0]   irq_clr;

    // Address LSBs and PWDATA bits beyond the register widths are don't-care.
    logic               unused_bits;
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    assign reg_addr = {apb.PADDR[4:2], 2'b00};
    assign access   = apb.PSEL & apb.PENABLE;

    // Error conditions for the addressed register; qualified by access below.
    always_comb begin
        err_raw = 1'b0;
        case (reg_addr)
            STATUS_OFS:   err_raw = apb.PWRITE;
            TXDATA_OFS:   err_raw = ~apb.PWRITE | tx_full;
            RXDATA_OFS:   err_raw = apb.PWRITE | rx_empty;
            UNMAPPED_OFS: err_raw = 1'b1;
            default:      err_raw = 1'b0;
        endcase
    end

    // Zero-wait slave: every access phase completes, so commit == access & ~err.
    assign slverr = access & err_raw;
    assign wr_ok  = access & ~err_raw & apb.PWRITE;
    assign rd_ok  = access & ~err_raw & ~apb.PWRITE;

    assign tx_push = wr_ok & (reg_addr == TXDATA_OFS);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_pop  = rd_ok & (reg_addr == RXDATA_OFS);
    // A full RX FIFO still takes a frame when the APB pop frees the head slot.
    assign rx_push = rx_valid & (~rx_full | rx_pop);
    assign rx_drop = rx_valid & ~rx_push;

    // TX push never coincides with a full FIFO, so no pop can make room for it.
    assign tx_empty_ev = tx_pop & ~tx_push & (tx_count == CW'(1));

    // STATUS word assembly.
    always_comb begin
        status = '0;
        status[ST_TX_FULL]                = tx_full;
        status[ST_TX_EMPTY]               = tx_empty;
        status[ST_RX_FULL]                = rx_full;
        status[ST_RX_EMPTY]               = rx_empty;
        status[ST_TX_COUNT +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
        status[ST_RX_COUNT +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
    end

    // Read mux; zero outside a successful read access.
    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            case (reg_addr)
                CTRL_OFS:     rdata = 32'(ctrl_q);
                STATUS_OFS:   rdata = status;
                RXDATA_OFS:   rdata = 32'(rx_head);
                IRQ_EN_OFS:   rdata = 32'(irq_en_q);
                IRQ_STAT_OFS: rdata = 32'(irq_stat_q);
                DIV_OFS:      rdata = 32'(div_q);
                default:      rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = access;
    assign apb.PSLVERR = slverr;

    // Sticky interrupt status: hardware set takes priority over W1C.
    always_comb begin
        irq_set               = '0;
        irq_set[IRQ_TX_EMPTY] = tx_empty_ev;
        irq_set[IRQ_RX_AVAIL] = rx_push;
        irq_set[IRQ_RX_OVF]   = rx_drop;
        irq_clr               = '0;
        if (wr_ok && (reg_addr == IRQ_STAT_OFS)) begin
            irq_clr = apb.PWDATA[IRQ_W-1:0];
        end
        irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
    end

    // Register writes, interrupt status and the registered interrupt line.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            ctrl_q     <= '0;
            div_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (reg_addr)
                    CTRL_OFS:   ctrl_q   <= ctrl_t'(apb.PWDATA[2:0]);
                    IRQ_EN_OFS: irq_en_q <= apb.PWDATA[IRQ_W-1:0];
                    DIV_OFS:    div_q    <= apb.PWDATA[7:0];
                    default:    ;
                endcase
            end
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign IRQ      = irq_q;
    assign spi_en   = ctrl_q.spi_en;
    assign cpol     = ctrl_q.cpol;
    assign cpha     = ctrl_q.cpha;
    assign clk_div  = div_q;
    assign tx_valid = ~tx_empty;

    spi_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .push    (tx_push),
        .pop     (tx_pop),
        .wdata   (apb.PWDATA[DATA_W-1:0]),
        .rdata   (tx_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    spi_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .push    (rx_push),
        .pop     (rx_pop),
        .wdata   (rx_data),
        .rdata   (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

endmodule

// File: tb/tb_spi_apb_regs.sv
// Scoreboard bench for spi_apb_regs: directed scenarios plus random traffic,
// checked against a queue-based model of the register block.
module tb_spi_apb_regs;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DMASK  = (1 << DATA_W) - 1;

    logic              PCLK = 1'b0;
    logic              PRESETN;
    logic              IRQ;
    logic              spi_en;
    logic              cpol;
    logic              cpha;
    logic [7:0]        clk_div;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    spi_apb_regs_if apb ();

    spi_apb_regs #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .apb      (apb),
        .IRQ      (IRQ),
        .spi_en   (spi_en),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int unsigned m_tx[$];
    int unsigned m_rx[$];
    int unsigned m_ctrl = 0;
    int unsigned m_div  = 0;
    int unsigned m_en   = 0;
    int unsigned m_stat = 0;
    bit          exp_irq = 1'b0;
    bit          mon_on  = 1'b0;

    typedef struct {
        int unsigned rdata;
        bit          err;
    } apb_rsp_t;

    apb_rsp_t    apb_exp[$];
    int unsigned tx_exp[$];
    apb_rsp_t    rsp;
    int unsigned tx_got;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned m_status();
        int unsigned s;
        s = 0;
        if (m_tx.size() == DEPTH) s |= 32'h1;
        if (m_tx.size() == 0)     s |= 32'h2;
        if (m_rx.size() == DEPTH) s |= 32'h4;
        if (m_rx.size() == 0)     s |= 32'h8;
        s |= (m_tx.size() << 4);
        s |= (m_rx.size() << 8);
        return s;
    endfunction

    function automatic bit m_err(bit wr, int idx);
        case (idx)
            1:       return wr;
            2:       return !wr || (m_tx.size() == DEPTH);
            3:       return wr || (m_rx.size() == 0);
            7:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int unsigned m_read(int idx);
        case (idx)
            0:       return m_ctrl;
            1:       return m_status();
            3:       return m_rx[0];
            4:       return m_en;
            5:       return m_stat;
            6:       return m_div;
            default: return 0;
        endcase
    endfunction

    // One clock of the model: predict this cycle's responses, wait for the
    // edge, then apply what the edge commits.
    task automatic cycle();
        bit          acc, wr, err, rst, txr, rxv;
        bit          tx_pop, tx_push, rx_pop, rx_push, drop, commit;
        int          idx;
        int unsigned wd, rxd, set, clr;
        acc = apb.PSEL && apb.PENABLE;
        wr  = apb.PWRITE;
        idx = int'(apb.PADDR[4:2]);
        wd  = apb.PWDATA;
        rst = !PRESETN;
        txr = tx_ready;
        rxv = rx_valid;
        rxd = 32'(rx_data);
        err = acc && m_err(wr, idx);
        if (acc) begin
            apb_exp.push_back('{rdata: (!err && !wr) ? m_read(idx) : 0, err: err});
        end
        if (txr && m_tx.size() > 0) tx_exp.push_back(m_tx[0]);
        @(posedge PCLK);
        exp_irq = (m_stat & m_en) != 0;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_ctrl  = 0;
            m_div   = 0;
            m_en    = 0;
            m_stat  = 0;
            exp_irq = 1'b0;
        end else begin
            commit  = acc && !err;
            tx_pop  = txr && m_tx.size() > 0;
            tx_push = commit && wr && idx == 2;
            rx_pop  = commit && !wr && idx == 3;
            rx_push = rxv && (m_rx.size() < DEPTH || rx_pop);
            drop    = rxv && !rx_push;
            set     = 0;
            clr     = 0;
            if (tx_pop && !tx_push && m_tx.size() == 1) set |= 1;
            if (rx_push) set |= 2;
            if (drop) set |= 4;
            if (commit && wr && idx == 5) clr = wd & 7;
            if (tx_pop) void'(m_tx.pop_front());
            if (tx_push) m_tx.push_back(wd & DMASK);
            if (rx_pop) void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(rxd & DMASK);
            if (commit && wr) begin
                case (idx)
                    0:       m_ctrl = wd & 7;
                    4:       m_en   = wd & 7;
                    6:       m_div  = wd & 32'hFF;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | set;
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic engine_rand();
        tx_ready = 1'($urandom_range(0, 1));
        rx_valid = ($urandom_range(0, 3) == 0);
        rx_data  = DATA_W'($urandom);
    endtask

    task automatic apb_xfer(bit wr, logic [4:0] addr, int unsigned data, bit rnd);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        if (rnd) engine_rand();
        cycle();
        apb.PENABLE = 1'b1;
        if (rnd) engine_rand();
        cycle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic rx_pulse(logic [DATA_W-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        cycle();
        rx_valid = 1'b0;
    endtask

    // Monitor: checks APB responses and engine handshakes against the scoreboard.
    always @(negedge PCLK) begin
        if (mon_on) begin
            if (apb.PSEL && apb.PENABLE) begin
                if (apb_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL apb_unexpected: access with no expected response at %0t", $time);
                end else begin
                    rsp = apb_exp.pop_front();
                    check("pready", 32'(apb.PREADY), 32'd1);
                    check("prdata", apb.PRDATA, rsp.rdata);
                    check("pslverr", 32'(apb.PSLVERR), 32'(rsp.err));
                end
            end else begin
                check("pready_idle", 32'(apb.PREADY), 32'd0);
                check("prdata_idle", apb.PRDATA, 32'd0);
                check("pslverr_idle", 32'(apb.PSLVERR), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no frame at %0t",
                             tx_data, $time);
                end else begin
                    tx_got = tx_exp.pop_front();
                    check("tx_frame", 32'(tx_data), tx_got);
                end
            end
            check("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
            check("irq", 32'(IRQ), 32'(exp_irq));
            check("ctrl_pins", {29'd0, cpha, cpol, spi_en}, m_ctrl);
            check("clk_div", 32'(clk_div), m_div);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETN     = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        idle(3);
        PRESETN = 1'b1;
        mon_on  = 1'b1;
        idle(1);

        // Reset values of every register.
        for (int i = 0; i < 8; i++) apb_xfer(1'b0, 5'(i * 4), 0, 1'b0);
        check("status_after_reset", m_status(), 32'hA);

        // Divider and control.
        apb_xfer(1'b1, 5'h18, 32'h1F5, 1'b0);
        apb_xfer(1'b0, 5'h18, 0, 1'b0);
        apb_xfer(1'b1, 5'h00, 32'h7, 1'b0);
        idle(1);

        // Fill TX, overflow push, then a rejected push coinciding with a pop.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) apb_xfer(1'b1, 5'h08, 32'hA1 + i, 1'b0);
        apb_xfer(1'b0, 5'h04, 0, 1'b0);
        apb_xfer(1'b1, 5'h08, 32'hA5, 1'b0);
        apb_xfer(1'b0, 5'h04, 0, 1'b0);
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PADDR  = 5'h08;
        apb.PWDATA = 32'hA6;
        cycle();
        apb.PENABLE = 1'b1;
        tx_ready    = 1'b1;
        cycle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        idle(6);
        tx_ready = 1'b0;
        apb_xfer(1'b0, 5'h14, 0, 1'b0);
        apb_xfer(1'b1, 5'h14, 32'h1, 1'b0);
        apb_xfer(1'b0, 5'h14, 0, 1'b0);

        // Push and pop in the same cycle on a partly filled TX FIFO.
        apb_xfer(1'b1, 5'h08, 32'hB1, 1'b0);
        apb_xfer(1'b1, 5'h08, 32'hB2, 1'b0);
        tx_ready = 1'b1;
        apb_xfer(1'b1, 5'h08, 32'hB3, 1'b0);
        idle(3);
        tx_ready = 1'b0;

        // RX available interrupt and its clear.
        apb_xfer(1'b1, 5'h10, 32'h2, 1'b0);
        rx_pulse(8'h5C);
        idle(2);
        apb_xfer(1'b0, 5'h0C, 0, 1'b0);
        apb_xfer(1'b1, 5'h14, 32'h2, 1'b0);
        idle(2);
        apb_xfer(1'b0, 5'h0C, 0, 1'b0);

        // RX overflow, then W1C racing a further overflow.
        for (int i = 0; i < 5; i++) rx_pulse(DATA_W'(8'h30 + i));
        apb_xfer(1'b0, 5'h14, 0, 1'b0);
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PADDR  = 5'h14;
        apb.PWDATA = 32'h4;
        cycle();
        apb.PENABLE = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = 8'h99;
        cycle();
        rx_valid    = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb_xfer(1'b0, 5'h14, 0, 1'b0);
        apb_xfer(1'b1, 5'h14, 32'h4, 1'b0);
        apb_xfer(1'b0, 5'h14, 0, 1'b0);
        for (int i = 0; i < 4; i++) apb_xfer(1'b0, 5'h0C, 0, 1'b0);

        // Error accesses.
        apb_xfer(1'b0, 5'h1C, 0, 1'b0);
        apb_xfer(1'b1, 5'h1C, 32'h55, 1'b0);
        apb_xfer(1'b0, 5'h08, 0, 1'b0);
        apb_xfer(1'b1, 5'h04, 32'h3, 1'b0);
        apb_xfer(1'b1, 5'h0C, 32'h3, 1'b0);

        // Reset asserted in the access phase of a DIV write.
        apb_xfer(1'b1, 5'h18, 32'h5A, 1'b0);
        apb_xfer(1'b1, 5'h08, 32'hC1, 1'b0);
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PADDR  = 5'h18;
        apb.PWDATA = 32'h77;
        cycle();
        apb.PENABLE = 1'b1;
        PRESETN     = 1'b0;
        cycle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        PRESETN     = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) apb_xfer(1'b0, 5'(i * 4), 0, 1'b0);

        // Random traffic on both bus and engine sides.
        for (int n = 0; n < 400; n++) begin
            apb_xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7) * 4), $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                engine_rand();
                cycle();
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        idle(8);
        tx_ready = 1'b0;
        idle(2);

        check("tx_scoreboard_drained", 32'(tx_exp.size()), 32'd0);
        check("apb_scoreboard_drained", 32'(apb_exp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
